// File: rtl/plot_pkg.sv
`default_nettype none
// ============================================================================
// Module   : plot_pkg
// Brief    : Shared screen geometry, pixel widths and scheduler state encoding.
// Revision : 1.0
// ============================================================================
package plot_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 3;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        START  = 2'd2,
        WAIT   = 2'd3
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/plot_mux.sv
`default_nettype none
// ============================================================================
// Module   : plot_mux
// Brief    : Registered N-to-1 pixel mux; outputs zero when not enabled.
// Revision : 1.0
// ============================================================================
module plot_mux
    import plot_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int IDX_W       = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid,
    input  logic [IDX_W-1:0]              idx,
    input  logic [NUM_CLIENTS-1:0]        client_we,
    input  logic [NUM_CLIENTS*X_W-1:0]    client_x,
    input  logic [NUM_CLIENTS*Y_W-1:0]    client_y,
    input  logic [NUM_CLIENTS*COLOUR_W-1:0] client_colour,
    output logic [X_W-1:0]                x,
    output logic [Y_W-1:0]                y,
    output logic [COLOUR_W-1:0]           colour,
    output logic                          writeEn
);

    logic [X_W-1:0]      sel_x;
    logic [Y_W-1:0]      sel_y;
    logic [COLOUR_W-1:0] sel_colour;
    logic                sel_we;

    always_comb begin
        sel_x      = client_x[idx*X_W +: X_W];
        sel_y      = client_y[idx*Y_W +: Y_W];
        sel_colour = client_colour[idx*COLOUR_W +: COLOUR_W];
        sel_we     = client_we[idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x       <= '0;
            y       <= '0;
            colour  <= '0;
            writeEn <= 1'b0;
        end else if (valid) begin
            x       <= sel_x;
            y       <= sel_y;
            colour  <= sel_colour;
            writeEn <= sel_we;
        end else begin
            x       <= '0;
            y       <= '0;
            colour  <= '0;
            writeEn <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/plot_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : plot_scheduler
// Brief    : Runs active draw clients in priority order each frame, sharing one
//            VGA adapter write port, with per-client timeout and tick queuing.
// Revision : 1.0
// ============================================================================
module plot_scheduler
    import plot_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int TIMEOUT     = 20000,
    parameter int IDX_W       = 2
) (
    input  logic                            CLOCK_50,
    input  logic                            reset,
    input  logic                            frame_tick,
    input  logic [NUM_CLIENTS-1:0]          client_active,
    input  logic [NUM_CLIENTS-1:0]          client_done,
    input  logic [NUM_CLIENTS-1:0]          client_we,
    input  logic [NUM_CLIENTS*X_W-1:0]      client_x,
    input  logic [NUM_CLIENTS*Y_W-1:0]      client_y,
    input  logic [NUM_CLIENTS*COLOUR_W-1:0] client_colour,
    output logic [NUM_CLIENTS-1:0]          client_start,
    output logic [X_W-1:0]                  x,
    output logic [Y_W-1:0]                  y,
    output logic [COLOUR_W-1:0]             colour,
    output logic                            writeEn,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            timeout_err,
    output logic [7:0]                      overrun_cnt
);

    localparam int              TIMER_W    = $clog2(TIMEOUT) + 1;
    localparam logic [IDX_W:0]  IDX_END    = (IDX_W+1)'(NUM_CLIENTS);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    sched_state_t        state, state_nx;
    logic [IDX_W:0]      idx, idx_nx;
    logic [TIMER_W-1:0]  timer, timer_nx;
    logic                pending, pending_nx;
    logic                timeout_hit;
    logic                overrun_inc;
    logic [IDX_W-1:0]    sel;

    assign sel = idx[IDX_W-1:0];

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            timer       <= '0;
            pending     <= 1'b0;
            timeout_err <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            timer   <= timer_nx;
            pending <= pending_nx;
            if (timeout_hit)
                timeout_err <= 1'b1;
            if (overrun_inc)
                overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        timer_nx    = timer;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (frame_tick || pending) begin
                    state_nx = SELECT;
                    idx_nx   = '0;
                end
            end
            SELECT: begin
                if (idx == IDX_END)
                    state_nx = IDLE;
                else if (client_active[sel])
                    state_nx = START;
                else
                    idx_nx = idx + 1'b1;
            end
            START: begin
                timer_nx = '0;
                state_nx = WAIT;
            end
            WAIT: begin
                timer_nx = timer + 1'b1;
                // done takes precedence over a timeout landing on the same cycle
                if (client_done[sel]) begin
                    idx_nx   = idx + 1'b1;
                    state_nx = SELECT;
                end else if (timer == TIMER_LAST) begin
                    timeout_hit = 1'b1;
                    idx_nx      = idx + 1'b1;
                    state_nx    = SELECT;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // A tick arriving as IDLE consumes a pending frame becomes the new pending one
    always_comb begin
        pending_nx  = pending;
        overrun_inc = 1'b0;
        if (state == IDLE) begin
            pending_nx = pending & frame_tick;
        end else if (frame_tick) begin
            if (pending)
                overrun_inc = (overrun_cnt != 8'hFF);
            else
                pending_nx = 1'b1;
        end
    end

    always_comb begin
        client_start = '0;
        if (state == START)
            client_start[sel] = 1'b1;
    end

    assign busy       = (state != IDLE);
    assign frame_done = (state == SELECT) && (idx == IDX_END);

    plot_mux #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .IDX_W       (IDX_W)
    ) u_mux (
        .clk           (CLOCK_50),
        .rst           (reset),
        .valid         (state == WAIT),
        .idx           (sel),
        .client_we     (client_we),
        .client_x      (client_x),
        .client_y      (client_y),
        .client_colour (client_colour),
        .x             (x),
        .y             (y),
        .colour        (colour),
        .writeEn       (writeEn)
    );

endmodule
`default_nettype wire

// File: tb/tb_plot_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_plot_scheduler
// Brief    : Scoreboard bench for plot_scheduler with a frame-level schedule model.
// Revision : 1.0
// ============================================================================
module tb_plot_scheduler;
    import plot_pkg::*;

    localparam int N  = 4;
    localparam int TO = 50;

    logic           clk = 1'b0;
    logic           rst;
    logic           frame_tick;
    logic [N-1:0]   act, done, we;
    logic [N*8-1:0] cx;
    logic [N*7-1:0] cy;
    logic [N*3-1:0] cc;
    logic [N-1:0]   start;
    logic [7:0]     x;
    logic [6:0]     y;
    logic [2:0]     colour;
    logic           wr, busy, fdone, to_err;
    logic [7:0]     ovr;

    plot_scheduler #(.NUM_CLIENTS(N), .TIMEOUT(TO), .IDX_W(2)) dut (
        .CLOCK_50(clk), .reset(rst), .frame_tick(frame_tick),
        .client_active(act), .client_done(done), .client_we(we),
        .client_x(cx), .client_y(cy), .client_colour(cc),
        .client_start(start), .x(x), .y(y), .colour(colour), .writeEn(wr),
        .busy(busy), .frame_done(fdone), .timeout_err(to_err), .overrun_cnt(ovr)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int idx; } start_ev_t;
    typedef struct { int cyc; logic [7:0] px; logic [6:0] py; logic [2:0] pc; } pix_t;

    start_ev_t start_q[$];
    pix_t      pix_q[$];
    int        fd_q[$];
    int        cyc = 0;
    int        checks = 0;
    int        failures = 0;
    int        fs[2][N];
    int        fe[2][N];
    int        ffd[2];
    int        obs_start[N];
    logic      exp_to;
    int        exp_ovr;
    start_ev_t se;
    pix_t      pe;

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_idle();
        frame_tick = 1'b0;
        act = '0; done = '0; we = '0;
        cx = '0; cy = '0; cc = '0;
    endtask

    task automatic quiet(input int n);
        for (int k = 0; k < n; k++) begin
            set_idle();
            next_cycle();
        end
    endtask

    // Frame accepted on tick cycle t0: each index costs one SELECT cycle; an active
    // client adds a START cycle and then holds the port until done or timeout.
    task automatic plan_frame(input int f, input int t0, input logic [N-1:0] a, input int d[N]);
        int t;
        int len;
        t = t0 + 1;
        for (int i = 0; i < N; i++) begin
            if (a[i]) begin
                fs[f][i] = t + 1;
                len = (d[i] == 0 || d[i] > TO) ? TO : d[i];
                fe[f][i] = fs[f][i] + len;
                t = fe[f][i] + 1;
                start_q.push_back('{fs[f][i], i});
                if (d[i] == 0 || d[i] > TO) exp_to = 1'b1;
            end else begin
                fs[f][i] = -100;
                fe[f][i] = -100;
                t = t + 1;
            end
        end
        ffd[f] = t;
        fd_q.push_back(t);
    endtask

    task automatic episode(input logic [N-1:0] a, input int d[N], input bit we_all,
                           input bit extra_ticks, input bit edge_px, input int abort_idx);
        int T;
        int nfr;
        int last;
        int own;
        T = cyc;
        nfr = 1;
        plan_frame(0, T, a, d);
        if (extra_ticks) begin
            plan_frame(1, ffd[0] + 1, a, d);
            nfr = 2;
            exp_ovr = (exp_ovr + 2 > 255) ? 255 : exp_ovr + 2;
        end
        last = ffd[nfr-1] + 3;
        for (int c = T; c <= last; c++) begin
            frame_tick = (c == T) || (extra_ticks && c >= T + 5 && c <= T + 7);
            act  = a;
            done = '0;
            for (int f = 0; f < nfr; f++)
                for (int i = 0; i < N; i++)
                    if (a[i] && d[i] != 0 && c == fs[f][i] + d[i]) done[i] = 1'b1;
            for (int i = 0; i < N; i++) begin
                we[i]        = we_all | 1'($urandom_range(0, 1));
                cx[8*i +: 8] = 8'($urandom_range(0, 159));
                cy[7*i +: 7] = 7'($urandom_range(0, 119));
                cc[3*i +: 3] = 3'($urandom_range(0, 7));
            end
            if (edge_px && a[0]) begin
                if (c == fs[0][0] + d[0]) begin
                    we[0] = 1'b1; cx[7:0] = 8'd159; cy[6:0] = 7'd119;
                end else if (c > fs[0][0] + d[0]) begin
                    we[0] = 1'b1;
                end
            end
            own = -1;
            for (int f = 0; f < nfr; f++)
                for (int i = 0; i < N; i++)
                    if (a[i] && c > fs[f][i] && c <= fe[f][i]) own = i;
            if (own >= 0 && we[own])
                pix_q.push_back('{c + 1, cx[8*own +: 8], cy[7*own +: 7], cc[3*own +: 3]});
            if (abort_idx >= 0 && c == fs[0][abort_idx] + 3) begin
                #1 rst = 1'b1;
                #1;
                check("reset_async_outputs",
                      {start, x, y, colour, wr, busy, fdone, to_err, ovr}, 0);
                start_q.delete(); pix_q.delete(); fd_q.delete();
                exp_to = 1'b0; exp_ovr = 0;
                quiet(2);
                rst = 1'b0;
                quiet(12);
                return;
            end
            next_cycle();
        end
        set_idle();
        check("busy_after_frame", busy, 0);
        check("timeout_err", to_err, exp_to);
        check("overrun_cnt", ovr, exp_ovr);
        check("missing_starts", start_q.size(), 0);
        check("missing_writes", pix_q.size(), 0);
        check("missing_frame_done", fd_q.size(), 0);
        start_q.delete(); pix_q.delete(); fd_q.delete();
    endtask

    always @(negedge clk) begin
        if (start != '0) begin
            for (int i = 0; i < N; i++)
                if (start[i]) obs_start[i] = cyc;
            if (start_q.size() == 0) begin
                check("unexpected_start", start, 0);
            end else begin
                se = start_q.pop_front();
                check("start_cycle", cyc, se.cyc);
                check("start_client", start, 1 << se.idx);
            end
        end
        if (wr) begin
            if (pix_q.size() == 0) begin
                check("unexpected_write", wr, 0);
            end else begin
                pe = pix_q.pop_front();
                check("write_cycle", cyc, pe.cyc);
                check("write_pixel", {x, y, colour}, {pe.px, pe.py, pe.pc});
            end
        end
        if (fdone) begin
            if (fd_q.size() == 0)
                check("unexpected_frame_done", fdone, 0);
            else
                check("frame_done_cycle", cyc, fd_q.pop_front());
        end
    end

    initial begin
        int dl[N];
        logic [N-1:0] ra;
        rst = 1'b1;
        set_idle();
        exp_to = 1'b0;
        exp_ovr = 0;
        for (int i = 0; i < N; i++) obs_start[i] = 0;
        next_cycle();
        next_cycle();
        check("reset_state", {start, x, y, colour, wr, busy, fdone, to_err, ovr}, 0);
        rst = 1'b0;
        quiet(2);

        dl = '{10, 10, 10, 10};
        episode(4'b1111, dl, 1'b0, 1'b0, 1'b0, -1);
        episode(4'b0101, dl, 1'b1, 1'b0, 1'b0, -1);

        dl = '{8, 0, 5, 7};
        episode(4'b1111, dl, 1'b0, 1'b0, 1'b0, -1);
        check("timeout_start_gap", obs_start[2] - obs_start[1], 52);

        dl = '{10, 10, 10, 10};
        episode(4'b1111, dl, 1'b0, 1'b1, 1'b0, -1);
        episode(4'b1111, dl, 1'b0, 1'b0, 1'b0, 2);

        dl = '{50, 3, 4, 5};
        episode(4'b1111, dl, 1'b0, 1'b0, 1'b0, -1);

        dl = '{6, 4, 4, 4};
        episode(4'b1111, dl, 1'b0, 1'b0, 1'b1, -1);

        dl = '{0, 0, 0, 0};
        episode(4'b0000, dl, 1'b1, 1'b0, 1'b0, -1);

        for (int r = 0; r < 6; r++) begin
            ra = 4'($urandom);
            for (int i = 0; i < N; i++) dl[i] = $urandom_range(1, 60);
            episode(ra, dl, 1'b0, 1'b0, 1'b0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
